// File: rtl/uart_packet_link_pkg.sv
// Shared types for the UART packet link: the UART_PACKET beat, framing constants
// and the FSM state encodings used by the framer, deframer and bit engine.
package uart_packet_link_pkg;

    localparam logic [7:0] UART_SYNC      = 8'h55;
    localparam logic [7:0] UART_BROADCAST = 8'hFF;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [2:0] {
        TX_IDLE, TX_SYNC, TX_DEST, TX_SRC, TX_LEN, TX_PAYLOAD
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_HUNT, RX_DEST, RX_SRC, RX_LEN, RX_PAYLOAD
    } rx_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP
    } bit_state_t;

    // Rounded clock-to-baud divisor.
    function automatic int calc_bit_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_packet_link_bit.sv
// Byte-level UART engine: TX shifter with back-to-back start capability and an
// RX sampler with start-bit validation and stop-bit framing check.
module uart_bit_engine
    import uart_packet_link_pkg::*;
#(
    parameter int BIT_DIV   = 10,
    parameter int STOP_BITS = 1
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic       rx_byte_stb_o,
    output logic       rx_frame_err_stb_o,
    output logic [7:0] rx_data_o
);

    localparam int               TX_BITS     = 9 + STOP_BITS;
    localparam int               DIV_W       = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(BIT_DIV / 2 - 1);
    localparam logic [3:0]       TX_LAST_BIT = 4'(TX_BITS - 1);

    logic [TX_BITS-1:0] tx_shift_q;
    logic [DIV_W-1:0]   tx_div_q;
    logic [3:0]         tx_bit_q;
    logic               tx_active_q;
    logic               tx_q;
    logic               tx_last;

    // Ready during the final stop-bit cycle so the next start bit follows with no gap.
    assign tx_last    = tx_active_q && (tx_div_q == DIV_LAST) && (tx_bit_q == TX_LAST_BIT);
    assign tx_ready_o = !tx_active_q || tx_last;
    assign tx_o       = tx_q;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            tx_active_q <= 1'b0;
            tx_shift_q  <= '1;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
            tx_q        <= 1'b1;
        end else if (tx_start_i && tx_ready_o) begin
            tx_shift_q  <= {{STOP_BITS{1'b1}}, tx_data_i, 1'b0};
            tx_q        <= 1'b0;
            tx_active_q <= 1'b1;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
        end else if (tx_active_q) begin
            if (tx_div_q == DIV_LAST) begin
                tx_div_q <= '0;
                if (tx_bit_q == TX_LAST_BIT) begin
                    tx_active_q <= 1'b0;
                    tx_q        <= 1'b1;
                end else begin
                    tx_bit_q   <= tx_bit_q + 4'd1;
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_q       <= tx_shift_q[1];
                end
            end else begin
                tx_div_q <= tx_div_q + 1'b1;
            end
        end
    end

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    bit_state_t       rx_state_q;
    logic [DIV_W-1:0] rx_div_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_stop_sample;

    assign rx_stop_sample     = (rx_state_q == BIT_STOP) && (rx_div_q == DIV_LAST);
    assign rx_byte_stb_o      = rx_stop_sample && rx_sync_q;
    assign rx_frame_err_stb_o = rx_stop_sample && !rx_sync_q;
    assign rx_data_o          = rx_shift_q;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= BIT_IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (rx_state_q)
                BIT_IDLE: begin
                    rx_div_q <= '0;
                    rx_bit_q <= '0;
                    if (rx_prev_q && !rx_sync_q) rx_state_q <= BIT_START;
                end
                BIT_START: begin
                    if (rx_div_q == DIV_HALF) begin
                        rx_div_q   <= '0;
                        rx_state_q <= rx_sync_q ? BIT_IDLE : BIT_DATA;
                    end else begin
                        rx_div_q <= rx_div_q + 1'b1;
                    end
                end
                BIT_DATA: begin
                    if (rx_div_q == DIV_LAST) begin
                        rx_div_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= BIT_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_div_q <= rx_div_q + 1'b1;
                    end
                end
                BIT_STOP: begin
                    if (rx_div_q == DIV_LAST) begin
                        rx_div_q   <= '0;
                        rx_state_q <= BIT_IDLE;
                    end else begin
                        rx_div_q <= rx_div_q + 1'b1;
                    end
                end
                default: rx_state_q <= BIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_packet_link.sv
// UART packet transceiver: TX framer (SYNC/Dest/Src/Len/payload) and RX deframer.
// Define UART_PACKET_ADDR_FILTER_EN to emit only packets for LOCAL_ADDR or broadcast.
module uart_packet_link
    import uart_packet_link_pkg::*;
#(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         BAUD       = 115_200,
    parameter logic [7:0] SYNC_BYTE  = UART_SYNC,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] LOCAL_ADDR = 8'h01
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  UART_PACKET ipTxStream,
    output logic       opTxReady,
    output logic       opTx,
    input  logic       ipRx,
    output UART_PACKET opRxStream,
    output logic       opRxFrameErr
);

    localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);
`ifdef UART_PACKET_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic       eng_tx_start, eng_tx_ready;
    logic [7:0] eng_tx_data;
    logic       eng_rx_byte, eng_rx_ferr;
    logic [7:0] eng_rx_data;

    uart_bit_engine #(
        .BIT_DIV  (BIT_DIV),
        .STOP_BITS(STOP_BITS)
    ) u_bit_engine (
        .ipClk             (ipClk),
        .ipReset           (ipReset),
        .tx_start_i        (eng_tx_start),
        .tx_data_i         (eng_tx_data),
        .tx_ready_o        (eng_tx_ready),
        .tx_o              (opTx),
        .rx_i              (ipRx),
        .rx_byte_stb_o     (eng_rx_byte),
        .rx_frame_err_stb_o(eng_rx_ferr),
        .rx_data_o         (eng_rx_data)
    );

    tx_state_t  tx_state_q;
    logic [7:0] tx_dest_q, tx_src_q, tx_len_q, tx_hold_q, tx_acc_q;
    logic       tx_hold_full_q, tx_ready_en_q;
    logic       tx_fire, tx_accept;
    logic       unused_tx_eop;

    // EoP on TX is advisory only; Length alone decides where the packet ends.
    assign unused_tx_eop = ipTxStream.EoP;

    always_comb begin
        eng_tx_start = 1'b0;
        eng_tx_data  = tx_hold_q;
        case (tx_state_q)
            TX_SYNC:    begin eng_tx_start = 1'b1; eng_tx_data = SYNC_BYTE; end
            TX_DEST:    begin eng_tx_start = 1'b1; eng_tx_data = tx_dest_q; end
            TX_SRC:     begin eng_tx_start = 1'b1; eng_tx_data = tx_src_q;  end
            TX_LEN:     begin eng_tx_start = 1'b1; eng_tx_data = tx_len_q;  end
            TX_PAYLOAD: eng_tx_start = tx_hold_full_q;
            default:    eng_tx_start = 1'b0;
        endcase
    end

    assign tx_fire   = eng_tx_start && eng_tx_ready;
    assign opTxReady = tx_ready_en_q &&
                       ((tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_PAYLOAD) && !tx_hold_full_q && (tx_acc_q < tx_len_q)));
    assign tx_accept = ipTxStream.Valid && opTxReady;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            tx_state_q     <= TX_IDLE;
            tx_dest_q      <= '0;
            tx_src_q       <= '0;
            tx_len_q       <= '0;
            tx_hold_q      <= '0;
            tx_acc_q       <= '0;
            tx_hold_full_q <= 1'b0;
            tx_ready_en_q  <= 1'b0;
        end else begin
            tx_ready_en_q <= 1'b1;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_accept && ipTxStream.SoP) begin
                        tx_dest_q      <= ipTxStream.Destination;
                        tx_src_q       <= ipTxStream.Source;
                        tx_len_q       <= ipTxStream.Length;
                        tx_hold_q      <= ipTxStream.Data;
                        tx_hold_full_q <= 1'b1;
                        tx_acc_q       <= 8'd1;
                        tx_state_q     <= TX_SYNC;
                    end
                end
                TX_SYNC: if (tx_fire) tx_state_q <= TX_DEST;
                TX_DEST: if (tx_fire) tx_state_q <= TX_SRC;
                TX_SRC:  if (tx_fire) tx_state_q <= TX_LEN;
                TX_LEN: begin
                    if (tx_fire) begin
                        if (tx_len_q == 8'd0) begin
                            tx_hold_full_q <= 1'b0;
                            tx_acc_q       <= '0;
                            tx_state_q     <= TX_IDLE;
                        end else begin
                            tx_state_q <= TX_PAYLOAD;
                        end
                    end
                end
                TX_PAYLOAD: begin
                    if (tx_accept) begin
                        tx_hold_q      <= ipTxStream.Data;
                        tx_hold_full_q <= 1'b1;
                        tx_acc_q       <= tx_acc_q + 8'd1;
                    end else if (tx_fire) begin
                        tx_hold_full_q <= 1'b0;
                        if (tx_acc_q == tx_len_q) begin
                            tx_acc_q   <= '0;
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    rx_state_t  rx_state_q;
    logic [7:0] rx_dest_q, rx_src_q, rx_len_q, rx_cnt_q;
    UART_PACKET rx_out_q;
    logic       rx_ferr_q;
    logic       rx_emit, rx_last;

    assign rx_emit      = !FILTER_EN || (rx_dest_q == LOCAL_ADDR) || (rx_dest_q == UART_BROADCAST);
    assign rx_last      = (rx_cnt_q + 8'd1) == rx_len_q;
    assign opRxStream   = rx_out_q;
    assign opRxFrameErr = rx_ferr_q;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            rx_state_q <= RX_HUNT;
            rx_dest_q  <= '0;
            rx_src_q   <= '0;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_out_q   <= '0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_out_q.Valid <= 1'b0;
            rx_out_q.SoP   <= 1'b0;
            rx_out_q.EoP   <= 1'b0;
            rx_ferr_q      <= eng_rx_ferr;
            if (eng_rx_ferr) begin
                rx_cnt_q   <= '0;
                rx_state_q <= RX_HUNT;
            end else if (eng_rx_byte) begin
                case (rx_state_q)
                    RX_HUNT: if (eng_rx_data == SYNC_BYTE) rx_state_q <= RX_DEST;
                    RX_DEST: begin rx_dest_q <= eng_rx_data; rx_state_q <= RX_SRC; end
                    RX_SRC:  begin rx_src_q  <= eng_rx_data; rx_state_q <= RX_LEN; end
                    RX_LEN: begin
                        rx_len_q   <= eng_rx_data;
                        rx_cnt_q   <= '0;
                        rx_state_q <= (eng_rx_data == 8'd0) ? RX_HUNT : RX_PAYLOAD;
                    end
                    RX_PAYLOAD: begin
                        if (rx_emit) begin
                            rx_out_q <= '{Source: rx_src_q, Destination: rx_dest_q,
                                          Length: rx_len_q, Data: eng_rx_data,
                                          SoP: (rx_cnt_q == 8'd0), EoP: rx_last, Valid: 1'b1};
                        end
                        if (rx_last) begin
                            rx_cnt_q   <= '0;
                            rx_state_q <= RX_HUNT;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 8'd1;
                        end
                    end
                    default: rx_state_q <= RX_HUNT;
                endcase
            end
        end
    end

endmodule
